ethernet_packet_tx: RTL and testbench
=====================================

# ethernet_packet_tx

Transmit-side packet source for the Ethernet sniffer datapath. It pulls tagged 32-bit words from a show-ahead packet FIFO and drives them as an Avalon-ST style stream (dataOut/sop/eop/empty/err/valid, with downstream ready), the same stream format the sniffer receives. It enforces packet framing, a maximum packet length and a minimum inter-packet gap, and keeps wrap-around packet and drop counters.

## Interface
- MAX_WORDS, 380, maximum words per packet (1518 B / 4, rounded up)
- IPG_CYCLES, 3, extra idle cycles enforced after each eop handoff
- CNT_W, 16, width of the statistics counters
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- fifo_q  in  36  FIFO head word {sop, eop, empty[1:0], data[31:0]}; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO has no head word
- rdreq  out  1  pop FIFO head at this edge (combinational)
- dataOut  out  32  stream data, first byte in [31:24]
- sop  out  1  first word of packet
- eop  out  1  last word of packet
- empty  out  2  unused bytes in the eop word
- err  out  1  packet truncated or malformed; only with eop=1
- valid  out  1  output word present
- ready  in  1  downstream accepts word this cycle
- pkt_count  out  CNT_W  packets whose eop was handed off (wraps)
- drop_count  out  CNT_W  FIFO words discarded (wraps)
- busy  out  1  state != IDLE or valid=1

## Operation
- Single output register. Handoff = valid && ready. Load = rdreq in IDLE/SEND: !fifo_empty && (!valid || ready) && no terminator pending.
- States: IDLE, SEND, DRAIN, GAP.
- IDLE: head sop=1 -> pop, load with sop=1, word_cnt=1; eop=1 -> GAP, else SEND. Head sop=0 -> pop, discard, drop_count+1, stay IDLE.
- SEND: head sop=0 -> pop, load with sop=0, word_cnt+1. Head eop=1 -> GAP. Loaded word is word MAX_WORDS without eop -> loaded with eop=1, err=1, empty=0; -> DRAIN.
- SEND, head sop=1 (unterminated packet): not popped; load terminator data=0, empty=3, eop=1, err=1; -> GAP. The sop word starts the next packet.
- DRAIN: pop every head word, drop_count+1 each, no output; popped word with eop=1 -> GAP. Head sop=1 -> not popped, -> GAP.
- GAP: no reads. Wait for handoff of the eop word (if still held), then count IPG_CYCLES cycles, then IDLE. IPG_CYCLES=0 -> IDLE the cycle after handoff.
- pkt_count +1 on each eop handoff, including err=1 packets.
- Counters wrap 2^CNT_W-1 -> 0. word_cnt is internal, width clog2(MAX_WORDS+1).

## Timing
- Reset (rst=1 at an edge): state IDLE; valid, sop, eop, err, empty, dataOut, pkt_count, drop_count all 0; busy 0; rdreq forced 0 while rst=1.
- Reset mid-packet: held word dropped, no eop emitted, FIFO not touched.
- Latency: word popped at edge N appears on outputs in cycle N+1.
- With valid=1 and ready=0, dataOut/sop/eop/empty/err held stable; no pop.
- Back-to-back: with ready=1 and FIFO non-empty, one word per cycle inside a packet.
- Between eop handoff and the next sop, valid is low for at least IPG_CYCLES+1 cycles.
- Simultaneous ready=1 and new head word: the held word hands off and the new word loads at the same edge.
- fifo_empty mid-packet: valid drops (bubble); no err; resumes when data returns.

## Test plan
- 3-word packet (sop/-/eop, empty=2) with ready=1: valid for 3 consecutive cycles, sop on word 1, eop+empty=2 on word 3; pkt_count=1; next sop no earlier than 4 idle cycles later.
- Same packet, ready toggling 1/0 every cycle: each word held stable while ready=0; words delivered in order, none lost or duplicated.
- 2 stray words (sop=0) before a sop packet: both popped, no output; drop_count=2; the packet then transmits normally.
- MAX_WORDS=4 and a 6-word packet: 4 words out, fourth with eop=1, err=1, empty=0; remaining 2 words drained; drop_count=2; pkt_count=1.
- Packet A with no eop, then sop of packet B: A ends with terminator (data 0, empty 3, eop, err); B sent intact after the gap; pkt_count=2.
- rst asserted while word 2 of 5 is held with ready=0: next cycle valid=0, counters=0, state IDLE, rdreq=0 during reset.

Source files
------------

// File: rtl/ethernet_packet_tx.sv
// Transmit packet source: pulls tagged words from a show-ahead FIFO and drives an
// Avalon-ST style stream with framing repair, a length limit and an inter-packet gap.
module ethernet_packet_tx #(
  parameter int MAX_WORDS  = 380,
  parameter int IPG_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [35:0]      fifo_q,
  input  logic             fifo_empty,
  output logic             rdreq,
  output logic [31:0]      dataOut,
  output logic             sop,
  output logic             eop,
  output logic [1:0]       empty,
  output logic             err,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);
  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int GCW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_e;

  state_e           state_q;
  logic [WCW-1:0]   word_cnt_q;
  logic [GCW-1:0]   gap_cnt_q;
  logic [31:0]      data_q;
  logic             sop_q, eop_q, err_q, valid_q;
  logic [1:0]       empty_q;
  logic [CNT_W-1:0] pkt_count_q, drop_count_q;

  logic             head_sop, head_eop;
  logic [1:0]       head_empty;
  logic [31:0]      head_data;
  logic             handoff, can_load;
  logic             load, term, drop, trunc;
  logic [WCW-1:0]   load_num;

  assign {head_sop, head_eop, head_empty, head_data} = fifo_q;

  always_comb begin
    handoff  = valid_q && ready;
    can_load = !valid_q || ready;
    load_num = (state_q == IDLE) ? WCW'(1) : word_cnt_q + WCW'(1);
    trunc    = (load_num == WCW'(MAX_WORDS)) && !head_eop;
    rdreq    = 1'b0;
    load     = 1'b0;
    term     = 1'b0;
    drop     = 1'b0;
    if (!rst && !fifo_empty) begin
      case (state_q)
        IDLE: if (can_load) begin
          rdreq = 1'b1;
          load  = head_sop;
          drop  = !head_sop;
        end
        // A new sop while a packet is open closes the old one with a synthetic
        // terminator; the sop word stays in the FIFO for the next packet.
        SEND: if (can_load) begin
          if (head_sop) begin
            term = 1'b1;
          end else begin
            rdreq = 1'b1;
            load  = 1'b1;
          end
        end
        DRAIN: if (!head_sop) begin
          rdreq = 1'b1;
          drop  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      data_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      empty_q      <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (handoff && eop_q) pkt_count_q <= pkt_count_q + 1'b1;
      if (drop) drop_count_q <= drop_count_q + 1'b1;

      if (load) begin
        valid_q    <= 1'b1;
        sop_q      <= head_sop;
        eop_q      <= head_eop || trunc;
        err_q      <= trunc;
        empty_q    <= head_eop ? head_empty : '0;
        data_q     <= head_data;
        word_cnt_q <= load_num;
      end else if (term) begin
        valid_q <= 1'b1;
        sop_q   <= 1'b0;
        eop_q   <= 1'b1;
        err_q   <= 1'b1;
        empty_q <= '1;
        data_q  <= '0;
      end else if (handoff) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE, SEND: if (load || term) begin
          gap_cnt_q <= '0;
          if (term || head_eop) state_q <= GAP;
          else if (trunc)       state_q <= DRAIN;
          else                  state_q <= SEND;
        end
        DRAIN: if (!fifo_empty && (head_sop || head_eop)) begin
          state_q   <= GAP;
          gap_cnt_q <= '0;
        end
        // The gap count only starts once the eop word has left the output register.
        GAP: begin
          if (valid_q) begin
            if (ready && IPG_CYCLES == 0) state_q <= IDLE;
          end else if (int'(gap_cnt_q) + 1 >= IPG_CYCLES) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataOut    = data_q;
  assign sop        = sop_q;
  assign eop        = eop_q;
  assign empty      = empty_q;
  assign err        = err_q;
  assign valid      = valid_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
  assign busy       = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_ethernet_packet_tx.sv
// Bench for ethernet_packet_tx: cycle table for a basic packet, directed corner cases,
// and random traffic scored against a packet-level reference model.
module tb_ethernet_packet_tx;
  localparam int MAXW = 4;
  localparam int IPG  = 3;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst, fifo_empty, rdreq, sop, eop, err, valid, ready, busy;
  logic [35:0]   fifo_q;
  logic [31:0]   dataOut;
  logic [1:0]    empty;
  logic [CW-1:0] pkt_count, drop_count;

  ethernet_packet_tx #(.MAX_WORDS(MAXW), .IPG_CYCLES(IPG), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_q(fifo_q), .fifo_empty(fifo_empty), .rdreq(rdreq),
    .dataOut(dataOut), .sop(sop), .eop(eop), .empty(empty), .err(err), .valid(valid),
    .ready(ready), .pkt_count(pkt_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic        e;
    logic [1:0]  emp;
    logic        er;
    logic [31:0] d;
  } oword_t;

  typedef struct {
    bit          push;
    logic [35:0] w;
    bit          rdy;
    bit          v;
    oword_t      o;
    bit          rq;
    int          pc;
    bit          bz;
  } row_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [35:0] fq[$];
  oword_t      exp_q[$];
  bit          sb_en = 0;

  bit          m_in = 0, m_drain = 0;
  int          m_n = 0, m_drops = 0, exp_pkts = 0;

  bit          hold_pend = 0, after_eop = 0;
  int          since_eop = 0;
  logic [37:0] held;

  function automatic logic [35:0] mkw(bit s, bit e, logic [1:0] emp, logic [31:0] d);
    return {s, e, emp, d};
  endfunction

  function automatic oword_t ow(bit s, bit e, logic [1:0] emp, bit er, logic [31:0] d);
    return oword_t'({s, e, emp, er, d});
  endfunction

  function automatic oword_t cur_out();
    return oword_t'({sop, eop, empty, err, dataOut});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_q     = fifo_empty ? '0 : fq[0];
  endtask

  // Packet-level view: what the stream must carry, in order, for the words fed in.
  task automatic model_word(input logic [35:0] w);
    bit s, e;
    s = w[35];
    e = w[34];
    if (m_drain) begin
      if (!s) begin
        m_drops++;
        if (e) m_drain = 0;
        return;
      end
      m_drain = 0;
    end
    if (m_in && s) begin
      exp_q.push_back(ow(0, 1, 2'd3, 1, 32'h0));
      m_in = 0;
    end
    if (!m_in) begin
      if (!s) begin
        m_drops++;
        return;
      end
      m_in = 1;
      m_n  = 0;
    end
    m_n++;
    if (e) begin
      exp_q.push_back(ow(s, 1, w[33:32], 0, w[31:0]));
      m_in = 0;
    end else if (m_n == MAXW) begin
      exp_q.push_back(ow(s, 1, 2'd0, 1, w[31:0]));
      m_in    = 0;
      m_drain = 1;
    end else begin
      exp_q.push_back(ow(s, 0, 2'd0, 0, w[31:0]));
    end
  endtask

  task automatic push(input logic [35:0] w);
    fq.push_back(w);
    drive_fifo();
    if (sb_en) model_word(w);
  endtask

  task automatic monitor();
    logic [37:0] cur;
    oword_t      e;
    cur = {valid, cur_out()};
    if (hold_pend) chk("hold_stable", cur, held);
    hold_pend = valid && !ready;
    held      = cur;
    if (valid && sop && after_eop) begin
      vectors++;
      if (since_eop < IPG + 1) begin
        miscompares++;
        $display("FAIL ipg_gap: got %0d idle cycles, expected at least %0d", since_eop, IPG + 1);
      end
      after_eop = 0;
    end
    if (!valid && after_eop) since_eop++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", cur_out(), '0);
      end else begin
        e = exp_q.pop_front();
        chk("stream_word", cur_out(), e);
        if (e.e) begin
          exp_pkts++;
          after_eop = 1;
          since_eop = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    bit pop;
    #2;
    pop = rdreq;
    if (sb_en) monitor();
    @(posedge clk);
    #1;
    if (pop) begin
      if (fq.size() == 0) chk("rdreq_on_empty", 1, 0);
      else void'(fq.pop_front());
    end
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string tag);
    int unsigned n;
    n = 0;
    ready = 1;
    while ((fq.size() != 0 || busy) && n < 400) begin
      cycle();
      n++;
    end
    vectors++;
    if (fq.size() != 0 || busy) begin
      miscompares++;
      $display("FAIL %s_quiet: busy=%0b fifo_words=%0d, expected idle within 400 cycles",
               tag, busy, fq.size());
    end
  endtask

  task automatic quiet_check(input string tag, input int ep, input int ed);
    chk({tag, "_pkt_count"}, pkt_count, ep & ((1 << CW) - 1));
    chk({tag, "_drop_count"}, drop_count, ed & ((1 << CW) - 1));
    chk({tag, "_words_outstanding"}, exp_q.size(), 0);
  endtask

  task automatic rand_push(input logic [35:0] w);
    repeat ($urandom_range(0, 2)) begin
      ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    push(w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[10];
    int   len;
    bit   term, last;
    logic [35:0] w1, w2, w3, wd;

    w1 = mkw(1, 0, 2'd0, 32'hA1A2A3A4);
    w2 = mkw(0, 0, 2'd0, 32'hB1B2B3B4);
    w3 = mkw(0, 1, 2'd2, 32'hC1C2C3C4);
    wd = mkw(1, 1, 2'd1, 32'hD1D2D3D4);
    tbl[0] = '{1, w1,  1, 0, '0, 1, 0, 0};
    tbl[1] = '{1, w2,  1, 1, ow(1, 0, 2'd0, 0, 32'hA1A2A3A4), 1, 0, 1};
    tbl[2] = '{1, w3,  1, 1, ow(0, 0, 2'd0, 0, 32'hB1B2B3B4), 1, 0, 1};
    tbl[3] = '{0, '0,  1, 1, ow(0, 1, 2'd2, 0, 32'hC1C2C3C4), 0, 0, 1};
    tbl[4] = '{1, wd,  1, 0, '0, 0, 1, 1};
    tbl[5] = '{0, '0,  1, 0, '0, 0, 1, 1};
    tbl[6] = '{0, '0,  1, 0, '0, 0, 1, 1};
    tbl[7] = '{0, '0,  1, 0, '0, 1, 1, 0};
    tbl[8] = '{0, '0,  1, 1, ow(1, 1, 2'd1, 0, 32'hD1D2D3D4), 0, 1, 1};
    tbl[9] = '{0, '0,  1, 0, '0, 0, 2, 1};

    rst = 1;
    ready = 0;
    drive_fifo();
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_valid", valid, 0);
    chk("reset_word", cur_out(), '0);
    chk("reset_pkt_count", pkt_count, 0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_busy", busy, 0);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].push) push(tbl[i].w);
      ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("tbl%0d_word", i), cur_out(), tbl[i].o);
      chk($sformatf("tbl%0d_rdreq", i), rdreq, tbl[i].rq);
      chk($sformatf("tbl%0d_pkt_count", i), pkt_count, tbl[i].pc);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
      cycle();
    end
    wait_quiet("table");
    quiet_check("table", 2, 0);

    exp_pkts = 2;
    m_drops  = 0;
    sb_en    = 1;

    push(mkw(1, 0, 2'd0, 32'h10000001));
    push(mkw(0, 0, 2'd0, 32'h10000002));
    push(mkw(0, 1, 2'd2, 32'h10000003));
    for (int i = 0; i < 16; i++) begin
      ready = (i % 2 == 0);
      cycle();
    end
    wait_quiet("toggle");
    quiet_check("toggle", 3, 0);

    push(mkw(0, 0, 2'd0, 32'h5A5A0001));
    push(mkw(0, 0, 2'd0, 32'h5A5A0002));
    push(mkw(1, 0, 2'd0, 32'h20000001));
    push(mkw(0, 0, 2'd0, 32'h20000002));
    push(mkw(0, 1, 2'd3, 32'h20000003));
    wait_quiet("stray");
    quiet_check("stray", 4, 2);

    for (int k = 1; k <= 6; k++) push(mkw(k == 1, k == 6, 2'd0, 32'h30000000 + k));
    wait_quiet("trunc");
    quiet_check("trunc", 5, 4);

    push(mkw(1, 0, 2'd0, 32'h40000001));
    push(mkw(0, 0, 2'd0, 32'h40000002));
    push(mkw(1, 0, 2'd0, 32'h50000001));
    push(mkw(0, 0, 2'd0, 32'h50000002));
    push(mkw(0, 1, 2'd1, 32'h50000003));
    wait_quiet("unterm");
    quiet_check("unterm", 7, 4);

    for (int p = 0; p < 30; p++) begin
      len  = $urandom_range(1, 6);
      term = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 5) == 0) rand_push(mkw(0, 0, 2'd0, $urandom));
      for (int k = 1; k <= len; k++) begin
        last = (k == len) && term;
        rand_push(mkw(k == 1, last, last ? 2'($urandom_range(0, 3)) : 2'd0, $urandom));
      end
    end
    rand_push(mkw(1, 0, 2'd0, $urandom));
    rand_push(mkw(0, 1, 2'd1, $urandom));
    wait_quiet("random");
    quiet_check("random", exp_pkts, m_drops);

    sb_en = 0;
    exp_q.delete();
    hold_pend = 0;
    ready = 1;
    push(mkw(1, 0, 2'd0, 32'hC0DE0001));
    push(mkw(0, 0, 2'd0, 32'hC0DE0002));
    push(mkw(0, 0, 2'd0, 32'hC0DE0003));
    push(mkw(0, 0, 2'd0, 32'hC0DE0004));
    push(mkw(0, 1, 2'd0, 32'hC0DE0005));
    cycle();
    cycle();
    ready = 0;
    chk("rst_pre_valid", valid, 1);
    chk("rst_pre_data", dataOut, 32'hC0DE0002);
    rst = 1;
    #1;
    chk("rst_rdreq_held", rdreq, 0);
    cycle();
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_word", cur_out(), '0);
    chk("rst_mid_pkt_count", pkt_count, 0);
    chk("rst_mid_drop_count", drop_count, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_fifo_words", fq.size(), 3);
    ready = 1;
    #1;
    chk("rst_mid_rdreq", rdreq, 0);
    rst = 0;
    wait_quiet("post_reset");
    quiet_check("post_reset", 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
